// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for instr_sequencer: widths, opcode field, opcodes and FSM state encoding.
`ifndef WORD_ADDR_BITS
`define WORD_ADDR_BITS 10
`endif

package instr_sequencer_pkg;

  localparam int INSTR_W = 105;
  localparam int PC_W    = `WORD_ADDR_BITS;
  localparam int CNT_W   = 16;
  localparam int OP_MSB  = 104;
  localparam int OP_LSB  = 102;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_ISSUE    = 3'd3,
    S_EXEC     = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  function automatic logic [2:0] op_of(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port plus Decoder/execution handshake for instr_sequencer.
// master = sequencer side, slave = memory/execution side.
interface instr_sequencer_if #(
  parameter int INSTR_W = instr_sequencer_pkg::INSTR_W,
  parameter int PC_W    = instr_sequencer_pkg::PC_W
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_rvalid;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               exec_ready;
  logic               exec_done;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_rdata, imem_rvalid, exec_ready, exec_done
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_rdata, imem_rvalid, exec_ready, exec_done
  );

endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue/complete sequencer for TPU instructions; stops on HALT and reports done.
// Optional INSTR_SEQ_SINGLE_STEP_EN adds step/step_mode gating of each issue.
module instr_sequencer #(
  parameter int INSTR_W = instr_sequencer_pkg::INSTR_W,
  parameter int PC_W    = instr_sequencer_pkg::PC_W,
  parameter int CNT_W   = instr_sequencer_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PC_W-1:0]    base_pc,
  instr_sequencer_if.master  bus,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic               step,
  input  logic               step_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   retired
);
  import instr_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, addr_q, addr_d;
  logic               req_q, req_d, iv_q, iv_d, busy_q, busy_d, done_q, done_d;
  logic               have_q, have_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic [INSTR_W-1:0] word_s;
  logic [PC_W-1:0]    pc_inc_s;
  logic [CNT_W-1:0]   ret_inc_s;
  logic               step_ok_s;

  // Once a word has been captured while waiting for a step, later rvalids are ignored.
  assign word_s    = have_q ? instr_q : bus.imem_rdata;
  assign pc_inc_s  = pc_q + PC_W'(1);
  assign ret_inc_s = (ret_q == RET_MAX) ? ret_q : ret_q + CNT_W'(1);

`ifdef INSTR_SEQ_SINGLE_STEP_EN
  logic step_pend_q, step_pend_d;
  assign step_ok_s = ~step_mode | step | step_pend_q;
`else
  assign step_ok_s = 1'b1;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = 1'b0;
    iv_d    = iv_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    done_d  = done_q;
    have_d  = have_q;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    step_pend_d = step_pend_q | (step & ((state_q == S_FETCH) | (state_q == S_WAIT_MEM)));
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = base_pc;
          addr_d  = base_pc;
          req_d   = 1'b1;
          ret_d   = '0;
          done_d  = 1'b0;
          state_d = S_FETCH;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
          step_pend_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (have_q || bus.imem_rvalid) begin
          instr_d = word_s;
          have_d  = 1'b1;
          if (op_of(word_s) == OP_HALT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            have_d  = 1'b0;
          end else if (step_ok_s) begin
            state_d = S_ISSUE;
            iv_d    = 1'b1;
            have_d  = 1'b0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
            step_pend_d = 1'b0;
`endif
          end else begin
            state_d = S_WAIT_MEM;
          end
        end else begin
          state_d = S_WAIT_MEM;
        end
      end
      S_ISSUE: begin
        if (bus.exec_ready) begin
          iv_d = 1'b0;
          // Completion in the accept cycle skips EXEC entirely.
          if (bus.exec_done) begin
            ret_d   = ret_inc_s;
            pc_d    = pc_inc_s;
            addr_d  = pc_inc_s;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          ret_d   = ret_inc_s;
          pc_d    = pc_inc_s;
          addr_d  = pc_inc_s;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_IDLE;
        iv_d    = 1'b0;
        have_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      iv_q    <= 1'b0;
      instr_q <= '0;
      ret_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      have_q  <= 1'b0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
      step_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      iv_q    <= iv_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      have_q  <= have_d;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
      step_pend_q <= step_pend_d;
`endif
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = iv_q;
  assign bus.instr       = instr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pc              = pc_q;
  assign retired         = ret_q;

endmodule
